// File: rtl/timer_pkg.sv
// timer_pkg: timer32 register map and scheduler state encoding shared by the design and bench
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PER,
        ST_WR_CTL,
        ST_RD_REQ,
        ST_RD_CHK,
        ST_WR_STOP
    } state_t;

    localparam logic [1:0] TMR_ADDR_PER = 2'b01;
    localparam logic [1:0] TMR_ADDR_CTL = 2'b10;
    localparam int TOGGLE_BIT = 2;

endpackage

// File: rtl/timer_sched.sv
// timer_sched: programs a timer32 peripheral, polls its toggle bit and turns each toggle into a tick
module timer_sched
    import timer_pkg::*;
#(
    parameter int ENBIT = 1,
    parameter logic [31:0] BASE_PERIOD = 32'h005F5E10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [2:0]       sel,
    output logic [1:0]       t_addr,
    output logic [31:0]      t_din,
    output logic             t_wren,
    output logic             t_rden,
    input  logic [31:0]      t_dout,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt,
    output logic             led
);

    state_t      state;
    state_t      nxt;
    logic [31:0] period;
    logic [31:0] per_next;
    logic        prev_tog;
    logic        accept;
    logic        changed;
    logic        unused_dout;

    assign unused_dout = ^t_dout;
    assign accept      = start && !stop && (state inside {ST_IDLE, ST_RD_REQ, ST_RD_CHK});
    assign per_next    = accept ? BASE_PERIOD << sel : period;
    assign changed     = (state == ST_RD_CHK) && (nxt == ST_RD_REQ) && (t_dout[TOGGLE_BIT] != prev_tog);

    // next state: stop beats start, a restart abandons the read in flight
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   nxt = accept ? ST_WR_PER : ST_IDLE;
            ST_WR_PER: nxt = stop ? ST_WR_STOP : ST_WR_CTL;
            ST_WR_CTL: nxt = stop ? ST_WR_STOP : ST_RD_REQ;
            ST_RD_REQ: nxt = stop ? ST_WR_STOP : accept ? ST_WR_PER : ST_RD_CHK;
            ST_RD_CHK: nxt = stop ? ST_WR_STOP : accept ? ST_WR_PER : ST_RD_REQ;
            default:   nxt = ST_IDLE;
        endcase
    end

    // bus strobes are registered from the upcoming state; the toggle history restarts with each programming
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            period   <= '0;
            prev_tog <= 1'b0;
            busy     <= 1'b0;
            t_wren   <= 1'b0;
            t_rden   <= 1'b0;
            t_addr   <= '0;
            t_din    <= '0;
            tick     <= 1'b0;
            tick_cnt <= '0;
            led      <= 1'b0;
        end else begin
            state  <= nxt;
            period <= per_next;
            busy   <= nxt != ST_IDLE;
            t_wren <= nxt inside {ST_WR_PER, ST_WR_CTL, ST_WR_STOP};
            t_rden <= nxt == ST_RD_REQ;
            t_addr <= (nxt == ST_WR_PER) ? TMR_ADDR_PER :
                      (nxt inside {ST_WR_CTL, ST_RD_REQ, ST_WR_STOP}) ? TMR_ADDR_CTL : 2'b00;
            t_din  <= (nxt == ST_WR_PER) ? per_next :
                      (nxt == ST_WR_CTL) ? 32'(1) << ENBIT : '0;
            tick   <= changed;
            if (accept) begin
                tick_cnt <= '0;
                prev_tog <= 1'b0;
            end else if (changed) begin
                tick_cnt <= tick_cnt + 1'b1;
                prev_tog <= t_dout[TOGGLE_BIT];
                led      <= t_dout[TOGGLE_BIT];
            end
        end
    end

endmodule
